// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the multi-approach traffic controller:
//   - per-approach 3-bit lamp encodings (RED, YEL, GRN, DARK)
//   - controller phase encodings as reported on the phase output
//   - idx_width(): width of the approach index bus for a given approach count
// ---------------------------------------------------------------------------
package traffic_pkg;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  // Index width is at least one bit, even for a single-bit selection.
  function automatic int idx_width(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// ---------------------------------------------------------------------------
// traffic_tick_gen
// Free-running prescaler producing the 1 s timing tick.
//   clk   : single clock
//   rst_n : synchronous active-low reset (counter returns to 0)
//   tick  : high for the one cycle in which the count equals TICK_DIV-1
// The count wraps on its own and is never restarted by the controller's
// phase changes, so phase durations are quantised to the global tick grid.
// ---------------------------------------------------------------------------
module traffic_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Prescaler count 0..TICK_DIV-1, wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/traffic_ctrl_multi.sv
// ---------------------------------------------------------------------------
// traffic_ctrl_multi
// Multi-approach signalised junction controller. One approach at a time owns
// the green; demand on other approaches is latched and served round-robin
// through YELLOW and ALLRED clearance. A flash request overrides everything
// and flashes all approaches yellow until released, then clears via ALLRED.
//   clk        : single clock
//   rst_n      : synchronous active-low reset
//   sensor     : per-approach vehicle demand (N_DIR bits)
//   flash_mode : fault/night flashing request
//   lights     : 3 bits per approach, approach i at [3i+2:3i]
//                (100 red, 010 yellow, 001 green, 000 dark)
//   green_idx  : approach that owns, or last owned, the green
//   phase      : 0 GREEN, 1 YELLOW, 2 ALLRED, 3 FLASH
// All outputs are registered.
// ---------------------------------------------------------------------------
module traffic_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int N_DIR     = 4,
  parameter int TICK_DIV  = 50000000,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 30,
  parameter int YEL_T     = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_DIR-1:0]                 sensor,
  input  logic                             flash_mode,
  output logic [3*N_DIR-1:0]               lights,
  output logic [idx_width(N_DIR)-1:0]      green_idx,
  output logic [1:0]                       phase
);

  localparam int IW   = idx_width(N_DIR);
  localparam int TMAX = (GREEN_MAX > YEL_T) ?
                        ((GREEN_MAX > ALLRED_T) ? GREEN_MAX : ALLRED_T) :
                        ((YEL_T > ALLRED_T) ? YEL_T : ALLRED_T);
  localparam int TW   = $clog2(TMAX + 1);

  // Lamp pattern for a given phase / owner / flash toggle state.
  function automatic logic [3*N_DIR-1:0] enc_lights(input phase_e ph,
                                                    input logic [IW-1:0] idx,
                                                    input logic fl);
    logic [3*N_DIR-1:0] v;
    v = {(3*N_DIR){1'b0}};
    for (int i = 0; i < N_DIR; i++) begin
      case (ph)
        PH_GREEN:  v[3*i +: 3] = (idx == IW'(i)) ? GRN : RED;
        PH_YELLOW: v[3*i +: 3] = (idx == IW'(i)) ? YEL : RED;
        PH_ALLRED: v[3*i +: 3] = RED;
        PH_FLASH:  v[3*i +: 3] = fl ? YEL : DARK;
        default:   v[3*i +: 3] = RED;
      endcase
    end
    return v;
  endfunction

  // Registered state and outputs
  phase_e             phase_r;
  logic [IW-1:0]      green_idx_r;
  logic [TW-1:0]      timer_r;
  logic [N_DIR-1:0]   req_pend_r;
  logic               flash_on_r;
  logic [3*N_DIR-1:0] lights_r;

  // Next-state values
  phase_e             nxt_phase_s;
  logic [IW-1:0]      nxt_idx_s;
  logic [TW-1:0]      nxt_timer_s;
  logic               nxt_flash_s;
  logic [N_DIR-1:0]   nxt_req_s;
  logic               enter_green_s;

  logic               tick_s;
  logic [TW:0]        timer_inc_s;
  logic [N_DIR-1:0]   owner_mask_s;
  logic               other_dem_s;
  logic               rr_found_s;
  logic [IW-1:0]      rr_idx_s;
  logic [IW-1:0]      rr_cand_s;

  traffic_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  assign timer_inc_s  = {1'b0, timer_r} + (TW+1)'(1);
  assign owner_mask_s = N_DIR'(1) << green_idx_r;
  // The owner's own pending bit never counts as demand to leave green.
  assign other_dem_s  = |(req_pend_r & ~owner_mask_s);

  // Round-robin search for the next owner, starting just after the current one
  // and wrapping back to it last; first pending approach wins.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = {IW{1'b0}};
    rr_cand_s  = {IW{1'b0}};
    for (int k = 1; k <= N_DIR; k++) begin
      rr_cand_s  = IW'((int'(green_idx_r) + k) % N_DIR);
      rr_idx_s   = (!rr_found_s && req_pend_r[rr_cand_s]) ? rr_cand_s : rr_idx_s;
      rr_found_s = rr_found_s | req_pend_r[rr_cand_s];
    end
  end

  // Phase sequencing: flash request first, then per-phase tick-driven timing.
  always_comb begin
    nxt_phase_s   = phase_r;
    nxt_idx_s     = green_idx_r;
    nxt_timer_s   = timer_r;
    nxt_flash_s   = flash_on_r;
    enter_green_s = 1'b0;
    if (flash_mode) begin
      if (phase_r == PH_FLASH) begin
        nxt_flash_s = tick_s ? ~flash_on_r : flash_on_r;
      end else begin
        nxt_phase_s = PH_FLASH;
        nxt_timer_s = {TW{1'b0}};
        nxt_flash_s = 1'b1;
      end
    end else begin
      case (phase_r)
        PH_GREEN: begin
          if (tick_s && other_dem_s &&
              ((timer_inc_s >= (TW+1)'(GREEN_MIN)) || (timer_inc_s == (TW+1)'(GREEN_MAX)))) begin
            nxt_phase_s = PH_YELLOW;
            nxt_timer_s = {TW{1'b0}};
          end else if (tick_s && (timer_r != TW'(GREEN_MAX))) begin
            nxt_timer_s = timer_inc_s[TW-1:0];
          end else begin
            nxt_timer_s = timer_r;
          end
        end
        PH_YELLOW: begin
          if (tick_s && (timer_r == TW'(YEL_T - 1))) begin
            nxt_phase_s = PH_ALLRED;
            nxt_timer_s = {TW{1'b0}};
          end else if (tick_s) begin
            nxt_timer_s = timer_inc_s[TW-1:0];
          end else begin
            nxt_timer_s = timer_r;
          end
        end
        PH_ALLRED: begin
          if (tick_s && (timer_r == TW'(ALLRED_T - 1))) begin
            nxt_phase_s   = PH_GREEN;
            nxt_timer_s   = {TW{1'b0}};
            nxt_idx_s     = rr_found_s ? rr_idx_s : {IW{1'b0}};
            enter_green_s = 1'b1;
          end else if (tick_s) begin
            nxt_timer_s = timer_inc_s[TW-1:0];
          end else begin
            nxt_timer_s = timer_r;
          end
        end
        PH_FLASH: begin
          nxt_phase_s = PH_ALLRED;
          nxt_timer_s = {TW{1'b0}};
        end
        default: begin
          // Unknown encoding: fall back to full clearance.
          nxt_phase_s = PH_ALLRED;
          nxt_timer_s = {TW{1'b0}};
        end
      endcase
    end
  end

  // Demand latching: sticky per approach, frozen for the green owner,
  // cleared for the approach that is being handed the green.
  always_comb begin
    nxt_req_s = req_pend_r;
    for (int i = 0; i < N_DIR; i++) begin
      if (enter_green_s && (nxt_idx_s == IW'(i))) begin
        nxt_req_s[i] = 1'b0;
      end else if ((phase_r == PH_GREEN) && (green_idx_r == IW'(i))) begin
        nxt_req_s[i] = req_pend_r[i];
      end else begin
        nxt_req_s[i] = req_pend_r[i] | sensor[i];
      end
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r     <= PH_GREEN;
      green_idx_r <= {IW{1'b0}};
      timer_r     <= {TW{1'b0}};
      req_pend_r  <= {N_DIR{1'b0}};
      flash_on_r  <= 1'b1;
      lights_r    <= enc_lights(PH_GREEN, {IW{1'b0}}, 1'b1);
    end else begin
      phase_r     <= nxt_phase_s;
      green_idx_r <= nxt_idx_s;
      timer_r     <= nxt_timer_s;
      req_pend_r  <= nxt_req_s;
      flash_on_r  <= nxt_flash_s;
      lights_r    <= enc_lights(nxt_phase_s, nxt_idx_s, nxt_flash_s);
    end
  end

  assign lights    = lights_r;
  assign green_idx = green_idx_r;
  assign phase     = phase_r;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_traffic_ctrl_multi
// Directed bench for traffic_ctrl_multi with N_DIR=4, TICK_DIV=4,
// GREEN_MIN=5, GREEN_MAX=10, YEL_T=3, ALLRED_T=1. Cycle numbers Pn count
// clock edges after the last reset edge (P0); with TICK_DIV=4 the k-th tick
// edge is P(4k). Outputs are sampled 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_traffic_ctrl_multi;

  localparam logic [11:0] L_RST = 12'b100_100_100_001;
  localparam logic [11:0] L_Y0  = 12'b100_100_100_010;
  localparam logic [11:0] L_AR  = 12'b100_100_100_100;
  localparam logic [11:0] L_G1  = 12'b100_100_001_100;
  localparam logic [11:0] L_G2  = 12'b100_001_100_100;
  localparam logic [11:0] L_G3  = 12'b001_100_100_100;
  localparam logic [11:0] L_FL  = 12'b010_010_010_010;
  localparam logic [11:0] L_DK  = 12'b000_000_000_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sensor = 4'b0000;
  logic        flash_mode = 1'b0;
  logic [11:0] lights;
  logic [1:0]  green_idx;
  logic [1:0]  phase;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  traffic_ctrl_multi #(
    .N_DIR     (4),
    .TICK_DIV  (4),
    .GREEN_MIN (5),
    .GREEN_MAX (10),
    .YEL_T     (3),
    .ALLRED_T  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor     (sensor),
    .flash_mode (flash_mode),
    .lights     (lights),
    .green_idx  (green_idx),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    cyc = cyc + n;
    #1;
  endtask

  task automatic go(input int target);
    adv(target - cyc);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] ph, input logic [1:0] idx,
                           input logic [11:0] lt);
    check({tag, ".phase"}, 32'(phase), 32'(ph));
    check({tag, ".idx"}, 32'(green_idx), 32'(idx));
    check({tag, ".lights"}, 32'(lights), 32'(lt));
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    sensor     = 4'b0000;
    flash_mode = 1'b0;
    adv(2);
    check_out("reset_hold", 2'd0, 2'd0, L_RST);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // Reset, then idle: approach 0 rests on green.
    do_reset();
    go(100);
    check_out("idle100", 2'd0, 2'd0, L_RST);

    // Single-cycle demand on approach 2 during tick 1.
    do_reset();
    go(3);  sensor = 4'b0100;
    go(4);  sensor = 4'b0000;
    go(19); check("s2.pre_yel", 32'(phase), 32'd0);
    go(20); check_out("s2.yel", 2'd1, 2'd0, L_Y0);
    go(31); check("s2.pre_ar", 32'(phase), 32'd1);
    go(32); check_out("s2.allred", 2'd2, 2'd0, L_AR);
    go(35); check("s2.ar_hold", 32'(phase), 32'd2);
    go(36); check_out("s2.green2", 2'd0, 2'd2, L_G2);
    check("s2.pend_clr", 32'(dut.req_pend_r[2]), 32'd0);

    // Round-robin: demand on 0 and 3 from owner 2 -> 3, then 0.
    sensor = 4'b1001;
    go(55); check("rr.pre_yel", 32'(phase), 32'd0);
    go(56); check("rr.yel", 32'(phase), 32'd1);
    go(72); check_out("rr.green3", 2'd0, 2'd3, L_G3);
    go(92); check("rr.yel3", 32'(phase), 32'd1);
    go(108); check_out("rr.green0", 2'd0, 2'd0, L_RST);
    sensor = 4'b0000;

    // Demand past GREEN_MIN: latched at tick 9, yellow at tick 10.
    do_reset();
    go(35); sensor = 4'b0010;
    go(36); check("late.t9", 32'(phase), 32'd0);
    sensor = 4'b0000;
    go(39); check("late.pre", 32'(phase), 32'd0);
    go(40); check_out("late.yel", 2'd1, 2'd0, L_Y0);
    go(56); check_out("late.green1", 2'd0, 2'd1, L_G1);

    // Flash entered mid-yellow, demand latched during flash.
    do_reset();
    sensor = 4'b1000;
    go(1);  sensor = 4'b0000;
    go(20); check("fl.yel", 32'(phase), 32'd1);
    go(25); flash_mode = 1'b1;
    go(26); check_out("fl.enter", 2'd3, 2'd0, L_FL);
    go(27); check("fl.hold", 32'(lights), 32'(L_FL));
    go(28); check("fl.dark", 32'(lights), 32'(L_DK));
    go(29); sensor = 4'b0010;
    go(30); sensor = 4'b0000;
    go(32); check("fl.on", 32'(lights), 32'(L_FL));
    go(33); check("fl.stay", 32'(phase), 32'd3);
    flash_mode = 1'b0;
    go(34); check_out("fl.allred", 2'd2, 2'd0, L_AR);
    go(35); check("fl.ar_hold", 32'(phase), 32'd2);
    go(36); check_out("fl.green1", 2'd0, 2'd1, L_G1);
    check("fl.pend3_kept", 32'(dut.req_pend_r[3]), 32'd1);
    flash_mode = 1'b1;
    go(37); check("fl2.enter", 32'(phase), 32'd3);
    flash_mode = 1'b0;
    go(38); check("fl2.allred", 32'(phase), 32'd2);
    go(40); check_out("fl2.green3", 2'd0, 2'd3, L_G3);
    flash_mode = 1'b1;
    go(41); flash_mode = 1'b0;
    go(42); check("fl3.allred", 32'(phase), 32'd2);
    go(44); check_out("fl3.none_to0", 2'd0, 2'd0, L_RST);

    // Reset pulse mid-ALLRED, with demand pending.
    flash_mode = 1'b1;
    go(45); flash_mode = 1'b0; sensor = 4'b0100;
    go(46); check("mr.allred", 32'(phase), 32'd2);
    sensor = 4'b0000; rst_n = 1'b0;
    go(47); check_out("mr.reset", 2'd0, 2'd0, L_RST);
    check("mr.pend", 32'(dut.req_pend_r), 32'd0);
    check("mr.timer", 32'(dut.timer_r), 32'd0);
    check("mr.presc", 32'(dut.u_tick.cnt_r), 32'd0);
    rst_n = 1'b1; cyc = 0;
    go(40); check_out("mr.rest", 2'd0, 2'd0, L_RST);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_multi.md
TRAFFIC_CTRL_MULTI -- requirements
Module: traffic_ctrl_multi

Interface
REQ-001 SHALL have parameter N_DIR, default 4, the number of approaches (legal range 2..8).
REQ-002 SHALL have parameter TICK_DIV, default 50000000, the clk cycles per 1 s timing tick (simulation uses 4).
REQ-003 SHALL have parameters GREEN_MIN 5, GREEN_MAX 30, YEL_T 3, ALLRED_T 1, all in ticks; legal only when GREEN_MAX >= GREEN_MIN >= 1, YEL_T >= 1 and ALLRED_T >= 1.
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit, reset; it is synchronous and active-low.
REQ-006 SHALL have port sensor, input, N_DIR bits, per-approach vehicle demand.
REQ-007 SHALL have port flash_mode, input, 1 bit, the fault/night flashing request.
REQ-008 SHALL have port lights, output, 3*N_DIR bits; bits [3i+2:3i] hold approach i as red=100, yellow=010, green=001, dark=000.
REQ-009 SHALL have port green_idx, output, max(1,clog2(N_DIR)) bits, the approach that currently owns or last owned the green.
REQ-010 SHALL have port phase, output, 2 bits: GREEN=0, YELLOW=1, ALLRED=2, FLASH=3.

Function
REQ-011 SHALL generate the tick from a free-running prescaler counting 0..TICK_DIV-1; tick=1 in the cycle where the count equals TICK_DIV-1. The prescaler is never reset by phase changes.
REQ-012 SHALL hold a phase timer; the timer clears on phase entry and increments on each tick, saturating at GREEN_MAX in GREEN.
REQ-013 SHALL latch sensor[i] into req_pend[i] every cycle, except for the approach currently green; req_pend[i] clears on entry to GREEN for i.
REQ-014 GREEN SHALL drive the approach green_idx to 001 and all other approaches to 100.
REQ-015 GREEN SHALL go to YELLOW on a tick when some other approach has demand and either timer+1 >= GREEN_MIN or timer+1 = GREEN_MAX.
REQ-016 With no other demand, GREEN SHALL rest indefinitely.
REQ-017 YELLOW SHALL drive approach green_idx to 010 and the others to 100; it SHALL go to ALLRED on the tick where timer = YEL_T-1.
REQ-018 ALLRED SHALL drive all approaches to 100; it SHALL go to GREEN on the tick where timer = ALLRED_T-1.
REQ-019 On ALLRED exit, green_idx SHALL become the first pending approach in round-robin order starting at green_idx+1 (mod N_DIR).
REQ-020 If no approach is pending at ALLRED exit, green_idx SHALL become 0.
REQ-021 Pending is sampled on the cycle of the ALLRED exit.
REQ-022 flash_mode=1 SHALL force FLASH on the next clock edge from any phase.
REQ-023 FLASH SHALL drive all approaches together, toggling between 010 and 000 on every tick, starting at 010.
REQ-024 Deasserting flash_mode SHALL move FLASH to ALLRED with the timer cleared; the ALLRED exit then follows REQ-019/020.
REQ-025 req_pend SHALL continue to latch during FLASH, and req_pend is not cleared by FLASH.
REQ-026 lights, green_idx and phase SHALL be registered outputs that change only on clk edges, and no two approaches are ever non-red simultaneously except in FLASH.

Reset
REQ-027 When rst_n=0 at a clk edge, the block SHALL set phase=GREEN, green_idx=0, lights = approach 0 at 001 and the others at 100, phase timer=0, prescaler=0, req_pend=0 and flash toggle=on.
REQ-028 Reset asserted in mid-phase SHALL abandon that phase immediately, with no yellow or all-red clearance.
REQ-029 The reset state SHALL hold for every cycle that rst_n=0.

Structure
REQ-030 Package traffic_pkg SHALL hold the light encodings (RED, YEL, GRN, DARK), the phase encodings, and a function that computes the green_idx width.
REQ-031 The prescaler SHALL be the sub-module traffic_tick_gen (parameter TICK_DIV; ports clk, rst_n, tick).
REQ-032 The next-approach round-robin search SHALL be combinational and bounded to N_DIR iterations.

Verification (N_DIR=4, TICK_DIV=4, GREEN_MIN=5, GREEN_MAX=10, YEL_T=3, ALLRED_T=1)
REQ-033 Stimulus: reset, then no sensors for 100 cycles -> approach 0 stays green, phase=0, lights=100_100_100_001.
REQ-034 Stimulus: pulse sensor[2] for 1 cycle at tick 1 -> YELLOW at tick 5, ALLRED at tick 8, GREEN with green_idx=2 at tick 9; req_pend[2] is 0.
REQ-035 Stimulus: with green_idx=2, hold sensor[0] and sensor[3] -> the next green goes to 3, then the one after goes to 0 (round-robin).
REQ-036 Stimulus: sensor[1] asserted at tick 9 of approach 0 green (past GREEN_MIN) -> YELLOW at tick 10.
REQ-037 Stimulus: assert flash_mode mid-YELLOW -> phase=3 next cycle, all lights 010/000 toggling per tick; deassert -> ALLRED for one tick, then green to the pending approach or to 0.
REQ-038 Stimulus: drop rst_n mid-ALLRED for 1 cycle -> the next cycle shows the exact reset outputs of REQ-027.
